serial_adder: RTL and testbench

//  Parametrised bit-serial add/subtract unit. A single full-adder cell is time-shared

---
 rtl/serial_adder.sv | 90 +++++++++
 tb/tb_serial_adder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial add/subtract: one full-adder cell time-shared over WIDTH cycles, LSB first.
// Latency: done observed WIDTH+1 edges after accept; start ignored while busy, accepted again in DONE.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int RW = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] opa, opb;
  logic [RW-1:0]   res;
  logic            c;
  logic            s, cnext, accept, last;

  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));
  assign s      = opa[0] ^ opb[0] ^ c;
  assign cnext  = (opa[0] & opb[0]) | (opa[0] & c) | (opb[0] & c);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN);
      done  <= (state_nxt == DONE);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Subtraction runs as a + ~b + ~cin, so cout=1 means no borrow.
  always_ff @(posedge clk) begin
    if (rst) begin
      opa  <= '0;
      opb  <= '0;
      res  <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (accept) begin
      opa <= a;
      opb <= sub ? ~b : b;
      c   <= sub ? ~cin : cin;
      cnt <= '0;
    end else if (state == RUN) begin
      opa <= opa >> 1;
      opb <= opb >> 1;
      res <= (res >> 1) | (RW'(s) << (RW - 1));
      c   <= cnext;
      cnt <= cnt + CW'(1);
      if (last) begin
        // c here is the carry into the MSB
        sum  <= {s, res};
        cout <= cnext;
        ovf  <= c ^ cnext;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboarded bench for serial_adder at WIDTH=8 (directed + random) and WIDTH=4 (exhaustive).
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8, start8, sub8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;
  logic       rst4, start4, sub4, cin4, busy4, done4, cout4, ovf4;
  logic [3:0] a4, b4, sum4;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .sub(sub4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } res_t;

  res_t q8[$];
  res_t q4[$];
  res_t e8, e4;
  int   checks = 0;
  int   errors = 0;
  int   dones4 = 0;
  int   accepts4 = 0;

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic res_t model(int w, logic s, longint x, longint y, logic ci);
    res_t   o;
    longint m, half, full, sx, sy, r;
    m    = longint'(1) << w;
    half = longint'(1) << (w - 1);
    full = s ? (x - y - longint'(ci) + m) : (x + y + longint'(ci));
    o.sum  = 8'(full % m);
    o.cout = (full >= m);
    sx = (x >= half) ? x - m : x;
    sy = (y >= half) ? y - m : y;
    r  = s ? (sx - sy - longint'(ci)) : (sx + sy + longint'(ci));
    o.ovf = (r < -half) || (r >= half);
    return o;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done8_spurious: got done with no pending op, expected none");
      end else begin
        e8 = q8.pop_front();
        chk("result8", {ovf8, cout8, sum8}, {e8.ovf, e8.cout, e8.sum});
      end
    end
    if (done4) begin
      dones4++;
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done4_spurious: got done with no pending op, expected none");
      end else begin
        e4 = q4.pop_front();
        chk("result4", {ovf4, cout4, sum4}, {e4.ovf, e4.cout, e4.sum[3:0]});
      end
    end
  end

  // Issue one op on dut8 at the current negedge and follow it to completion.
  // ign_at>0: pulse a junk start that many cycles in. rst_at>0: abort by reset.
  task automatic op8(input logic s, input logic [7:0] x, input logic [7:0] y,
                     input logic ci, input int ign_at, input int rst_at);
    int nbusy;
    nbusy = 0;
    sub8 = s; a8 = x; b8 = y; cin8 = ci; start8 = 1'b1;
    if (rst_at == 0) q8.push_back(model(8, s, longint'(x), longint'(y), ci));
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom);
        sub8 = 1'($urandom); cin8 = 1'($urandom);
      end
      if (ign_at > 1 && n == ign_at) begin
        start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
      end
      if (ign_at > 1 && n == ign_at + 1) start8 = 1'b0;
      if (rst_at > 0 && n == rst_at) rst8 = 1'b1;
      if (rst_at > 0 && n == rst_at + 1) begin
        rst8 = 1'b0;
        chk("abort_outputs", {busy8, done8, cout8, ovf8, sum8}, 64'h0);
        return;
      end
      if (done8) begin
        chk("latency8", 64'(n), 64'd9);
        chk("busy_cycles8", 64'(nbusy), 64'd8);
        chk("busy_at_done8", {63'h0, busy8}, 64'h0);
        return;
      end
      if (busy8) nbusy++;
    end
    checks++;
    errors++;
    $display("FAIL timeout8: got no done within 12 cycles, expected done at 9");
  endtask

  initial begin
    rst8 = 1'b1; start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    rst4 = 1'b1; start4 = 1'b0; sub4 = 1'b0; cin4 = 1'b0; a4 = '0; b4 = '0;
    repeat (3) @(negedge clk);
    chk("reset8", {busy8, done8, cout8, ovf8, sum8}, 64'h0);
    chk("reset4", {busy4, done4, cout4, ovf4, sum4}, 64'h0);
    rst8 = 1'b0; rst4 = 1'b0;
    @(negedge clk);

    op8(1'b0, 8'h35, 8'h4A, 1'b0, 0, 0);
    chk("t1_sum", {ovf8, cout8, sum8}, {2'b00, 8'h7F});
    repeat (2) @(negedge clk);
    op8(1'b0, 8'h7F, 8'h01, 1'b0, 0, 0);
    chk("t2a", {ovf8, cout8, sum8}, {2'b10, 8'h80});
    op8(1'b0, 8'hFF, 8'h00, 1'b1, 0, 0);
    chk("t2b", {ovf8, cout8, sum8}, {2'b01, 8'h00});
    op8(1'b1, 8'h10, 8'h20, 1'b0, 0, 0);
    chk("t3a", {ovf8, cout8, sum8}, {2'b00, 8'hF0});
    op8(1'b1, 8'h80, 8'h01, 1'b0, 0, 0);
    chk("t3b", {ovf8, cout8, sum8}, {2'b11, 8'h7F});

    @(negedge clk);
    op8(1'b0, 8'h12, 8'h34, 1'b0, 3, 0);
    chk("t4_ignored", {ovf8, cout8, sum8}, {2'b00, 8'h46});
    op8(1'b0, 8'h01, 8'h02, 1'b1, 0, 0);
    chk("t4_backtoback", {ovf8, cout8, sum8}, {2'b00, 8'h04});

    op8(1'b1, 8'h55, 8'h22, 1'b1, 0, 4);
    repeat (12) @(negedge clk);
    op8(1'b0, 8'h20, 8'h30, 1'b1, 0, 0);
    chk("t5_after_reset", {ovf8, cout8, sum8}, {2'b00, 8'h51});

    for (int i = 0; i < 60; i++) begin
      op8(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 0, 0);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    // Exhaustive WIDTH=4, each op issued in the DONE cycle of the previous one.
    for (int s = 0; s < 2; s++)
      for (int ci = 0; ci < 2; ci++)
        for (int x = 0; x < 16; x++)
          for (int y = 0; y < 16; y++) begin
            int t;
            sub4 = 1'(s); cin4 = 1'(ci); a4 = 4'(x); b4 = 4'(y); start4 = 1'b1;
            q4.push_back(model(4, 1'(s), longint'(x), longint'(y), 1'(ci)));
            accepts4++;
            @(negedge clk);
            start4 = 1'b0;
            a4 = 4'($urandom); b4 = 4'($urandom);
            t = 0;
            while (!done4 && t < 20) begin
              @(negedge clk);
              t++;
            end
            if (!done4) begin
              checks++;
              errors++;
              $display("FAIL timeout4: got no done within 20 cycles, expected done at 5");
            end
          end

    repeat (4) @(negedge clk);
    chk("done_count4", 64'(dones4), 64'(accepts4));
    chk("pending8", 64'(q8.size()), 64'd0);
    chk("pending4", 64'(q4.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish by 500000, expected earlier finish");
    $fatal(1, "timeout");
  end

endmodule
